// File: rtl/hedios_packet_fifo.sv
// Packet FIFO between the HEDIOS link front-end and the command dispatcher.
// Holds DEPTH command/data pairs and offers either a registered read port or a fall-through read port.
module hedios_packet_fifo #(
    parameter int CMD_WIDTH    = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 8,
    parameter int FWFT         = 0,
    parameter int AFULL_LEVEL  = DEPTH - 1,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         clear_flags,
    input  logic                         push_packet,
    input  logic [CMD_WIDTH-1:0]         i_packet_command,
    input  logic [DATA_WIDTH-1:0]        i_packet_data,
    input  logic                         pop_packet,
    output logic [CMD_WIDTH-1:0]         o_packet_command,
    output logic [DATA_WIDTH-1:0]        o_packet_data,
    output logic                         o_valid,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_empty,
    output logic                         almost_full,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [CMD_WIDTH-1:0]  r_mem_cmd  [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop_ok;
    logic                  w_push_ok;
    logic [LW-1:0]         w_level_nxt;
    logic                  w_overflow_nxt;
    logic                  w_underflow_nxt;

    // Pointer advance with an explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = PTR_ZERO;
        end else begin
            nxt = ptr + PTR_ONE;
        end
        return nxt;
    endfunction

    assign w_empty   = (r_level == LVL_ZERO);
    assign w_full    = (r_level == LVL_FULL);
    assign w_pop_ok  = pop_packet & ~w_empty;
    // A push into a full FIFO is only taken when the same cycle frees a slot.
    assign w_push_ok = push_packet & (~w_full | w_pop_ok);

    // Next fill level and next sticky-flag values (set wins over clear).
    always_comb begin
        w_level_nxt     = r_level;
        w_overflow_nxt  = (push_packet & ~w_push_ok) | (r_overflow  & ~clear_flags);
        w_underflow_nxt = (pop_packet  & ~w_pop_ok)  | (r_underflow & ~clear_flags);
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_level_nxt = r_level + LVL_ONE;
            2'b01:   w_level_nxt = r_level - LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    // Pointers, level and error flags; flush empties the queue but leaves the flags alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= PTR_ZERO;
            r_rd_ptr    <= PTR_ZERO;
            r_level     <= LVL_ZERO;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= PTR_ZERO;
            r_rd_ptr    <= PTR_ZERO;
            r_level     <= LVL_ZERO;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_level     <= w_level_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    // Packet storage; contents survive flush and reset, only the pointers move.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_push_ok) begin
            r_mem_cmd[r_wr_ptr]  <= i_packet_command;
            r_mem_data[r_wr_ptr] <= i_packet_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign o_packet_command = r_mem_cmd[r_rd_ptr];
            assign o_packet_data    = r_mem_data[r_rd_ptr];
            assign o_valid          = ~w_empty;
        end else begin : g_registered
            logic [CMD_WIDTH-1:0]  r_out_cmd;
            logic [DATA_WIDTH-1:0] r_out_data;
            logic                  r_out_valid;

            // Registered read port: fields load on an accepted pop and hold otherwise.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out_cmd   <= {CMD_WIDTH{1'b0}};
                    r_out_data  <= {DATA_WIDTH{1'b0}};
                    r_out_valid <= 1'b0;
                end else if (flush) begin
                    r_out_valid <= 1'b0;
                end else if (w_pop_ok) begin
                    r_out_cmd   <= r_mem_cmd[r_rd_ptr];
                    r_out_data  <= r_mem_data[r_rd_ptr];
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end

            assign o_packet_command = r_out_cmd;
            assign o_packet_data    = r_out_data;
            assign o_valid          = r_out_valid;
        end
    endgenerate

    assign empty        = w_empty;
    assign full         = w_full;
    assign level        = r_level;
    assign almost_empty = ({{(32-LW){1'b0}}, r_level} <= AEMPTY_LEVEL);
    assign almost_full  = ({{(32-LW){1'b0}}, r_level} >= AFULL_LEVEL);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_hedios_packet_fifo.sv
// Scoreboard bench: one stimulus stream drives a registered-read and a fall-through instance (DEPTH=5).
module tb_hedios_packet_fifo;

    typedef struct packed {
        logic [7:0]  c;
        logic [31:0] d;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        clr = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [7:0]  icmd = 8'h00;
    logic [31:0] idata = 32'h0;

    logic [7:0]  a_cmd, b_cmd;
    logic [31:0] a_data, b_data;
    logic        a_valid, a_empty, a_full, a_aempty, a_afull, a_ovf, a_unf;
    logic        b_valid, b_empty, b_full, b_aempty, b_afull, b_ovf, b_unf;
    logic [2:0]  a_level, b_level;

    int   n_tests = 0;
    int   n_fail  = 0;
    pkt_t q[$];
    bit   m_ovf, m_unf, m_valid;
    logic [7:0]  m_cmd;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    hedios_packet_fifo #(.CMD_WIDTH(8), .DATA_WIDTH(32), .DEPTH(5), .FWFT(0)) dut_reg (
        .clk(clk), .rst(rst), .flush(flush), .clear_flags(clr),
        .push_packet(push), .i_packet_command(icmd), .i_packet_data(idata),
        .pop_packet(pop), .o_packet_command(a_cmd), .o_packet_data(a_data),
        .o_valid(a_valid), .empty(a_empty), .full(a_full),
        .almost_empty(a_aempty), .almost_full(a_afull), .level(a_level),
        .overflow(a_ovf), .underflow(a_unf)
    );

    hedios_packet_fifo #(.CMD_WIDTH(8), .DATA_WIDTH(32), .DEPTH(5), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .flush(flush), .clear_flags(clr),
        .push_packet(push), .i_packet_command(icmd), .i_packet_data(idata),
        .pop_packet(pop), .o_packet_command(b_cmd), .o_packet_data(b_data),
        .o_valid(b_valid), .empty(b_empty), .full(b_full),
        .almost_empty(b_aempty), .almost_full(b_afull), .level(b_level),
        .overflow(b_ovf), .underflow(b_unf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int lv;
        lv = q.size();
        chk("a_level",  64'(a_level),  64'(lv));
        chk("b_level",  64'(b_level),  64'(lv));
        chk("empty",    64'(a_empty),  64'(lv == 0));
        chk("full",     64'(a_full),   64'(lv == 5));
        chk("aempty",   64'(a_aempty), 64'(lv <= 1));
        chk("afull",    64'(a_afull),  64'(lv >= 4));
        chk("b_full",   64'(b_full),   64'(lv == 5));
        chk("b_empty",  64'(b_empty),  64'(lv == 0));
        chk("overflow", 64'(a_ovf),    64'(m_ovf));
        chk("underflow",64'(a_unf),    64'(m_unf));
        chk("b_ovf",    64'(b_ovf),    64'(m_ovf));
        chk("b_unf",    64'(b_unf),    64'(m_unf));
        chk("a_valid",  64'(a_valid),  64'(m_valid));
        chk("a_cmd",    64'(a_cmd),    64'(m_cmd));
        chk("a_data",   64'(a_data),   64'(m_data));
        chk("b_valid",  64'(b_valid),  64'(lv != 0));
        if (lv != 0) begin
            chk("b_cmd",  64'(b_cmd),  64'(q[0].c));
            chk("b_data", 64'(b_data), 64'(q[0].d));
        end
    endtask

    task automatic step(input bit ps, input logic [7:0] c, input logic [31:0] d,
                        input bit pp, input bit fl, input bit cl);
        bit   pop_ok, push_ok;
        pkt_t h;
        push = ps; icmd = c; idata = d; pop = pp; flush = fl; clr = cl;
        pop_ok  = pp && (q.size() != 0);
        push_ok = ps && ((q.size() < 5) || pop_ok);
        if (fl) begin
            q.delete();
            m_valid = 1'b0;
        end else begin
            m_ovf   = (ps && !push_ok) || (m_ovf && !cl);
            m_unf   = (pp && !pop_ok)  || (m_unf && !cl);
            m_valid = pop_ok;
            if (pop_ok) begin
                h = q.pop_front();
                m_cmd  = h.c;
                m_data = h.d;
            end
            if (push_ok) begin
                q.push_back({c, d});
            end
        end
        @(posedge clk);
        #1;
        check_all();
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset(input bit pp);
        rst = 1'b1;
        pop = pp;
        q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0;
        m_cmd = 8'h00; m_data = 32'h0;
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        pop = 1'b0;
    endtask

    initial begin
        do_reset(1'b0);

        // Fill to full, one dropped push, drain in order.
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 32'h100 + 32'(i - 1), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h06, 32'h105, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);

        // Pointer wrap with interleaved push/pop.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h20 + i), 32'(32'h2000 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'(8'h10 + i), 32'(32'h1000 + i), 1'b0, 1'b0, 1'b0);
            step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
        end

        // Simultaneous push+pop at full, then at empty.
        step(1'b1, 8'h50, 32'h5000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h51, 32'h5001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 32'hAAAA_0000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h33, 32'h3333, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);

        // Flush with a concurrent push, then underflow and clear.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 32'(32'h6000 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h70, 32'h7000, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);

        // Fall-through visibility without a pop, then consume.
        step(1'b1, 8'h42, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of traffic with pop held.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h80 + i), 32'(32'h8000 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h90, 32'h9000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
        do_reset(1'b1);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 55, 8'($urandom), $urandom,
                 $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 5);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
